// File: rtl/vend_if.sv
`default_nettype none
// ============================================================================
// Module      : vend_if
// Description : Button/coin/hopper/display bundle for the vending controller.
//               The master drives coins, selections, cancel and hopper ready.
//               The slave (controller) drives change, credit and indicators.
// Revision    : 1.0  initial release
// ============================================================================
interface vend_if #(
    parameter int NUM_SLOTS = 9,
    parameter int CREDIT_W  = 10
);
    logic [5:0]           coinIn;
    logic [NUM_SLOTS-1:0] slotSel;
    logic                 cancel;
    logic                 changeReady;
    logic                 changeValid;
    logic [2:0]           changeCoin;
    logic                 coinReject;
    logic [CREDIT_W-1:0]  credit;
    logic [CREDIT_W-1:0]  dispValue;
    logic [NUM_SLOTS-1:0] greenLed;
    logic [NUM_SLOTS-1:0] redLed;
    logic [NUM_SLOTS-1:0] dispLed;
    logic                 busy;

    modport master (
        output coinIn, slotSel, cancel, changeReady,
        input  changeValid, changeCoin, coinReject, credit, dispValue,
               greenLed, redLed, dispLed, busy
    );

    modport slave (
        input  coinIn, slotSel, cancel, changeReady,
        output changeValid, changeCoin, coinReject, credit, dispValue,
               greenLed, redLed, dispLed, busy
    );
endinterface
`default_nettype wire

// File: rtl/vend_controller_n.sv
`default_nettype none
// ============================================================================
// Module      : vend_controller_n
// Description : Parametrised vending-machine core. Per-slot price table,
//               saturating credit, timed price-check / vend indications and
//               handshaked greedy change return.
//               Optional feature macro: STOCK_TRACK_EN (per-slot stock count).
// Revision    : 1.0  initial release
// ============================================================================
module vend_controller_n #(
    parameter int NUM_SLOTS   = 9,
    parameter int CREDIT_W    = 10,
    parameter logic [NUM_SLOTS*CREDIT_W-1:0] PRICES = {
        10'd275, 10'd250, 10'd225, 10'd200, 10'd175,
        10'd150, 10'd125, 10'd100, 10'd75 },
    parameter int MAX_CREDIT  = 995,
    parameter int SHOW_CYCLES = 4,
    parameter int VEND_CYCLES = 2,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 3
) (
    input wire logic clk,
    input wire logic reset,
    vend_if.slave    bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHOW   = 2'd1;
    localparam logic [1:0] c_ST_VEND   = 2'd2;
    localparam logic [1:0] c_ST_CHANGE = 2'd3;

    // Sum width must hold credit plus the largest coin (500) without wrap.
    localparam int c_SUM_W   = ((CREDIT_W > 9) ? CREDIT_W : 9) + 1;
    localparam int c_TMR_MAX = (SHOW_CYCLES > VEND_CYCLES) ? SHOW_CYCLES : VEND_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [1:0]           r_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [CREDIT_W-1:0]  r_credit;
    logic [CREDIT_W-1:0]  r_showPrice;
    logic                 r_changeValid;
    logic [2:0]           r_changeCoin;
    logic                 r_coinReject;
    logic [NUM_SLOTS-1:0] r_greenLed;
    logic [NUM_SLOTS-1:0] r_redLed;
    logic [NUM_SLOTS-1:0] r_dispLed;

    logic [CREDIT_W-1:0]  w_price [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_inStock;
    logic [NUM_SLOTS-1:0] w_afford;
    logic [c_SUM_W-1:0]   w_coinValue;
    logic                 w_coinOne;
    logic [c_SUM_W-1:0]   w_coinSum;
    logic                 w_coinFits;
    logic                 w_selValid;
    logic [c_IDX_W-1:0]   w_selIdx;
    logic [NUM_SLOTS-1:0] w_selOneHot;
    logic [CREDIT_W-1:0]  w_selPrice;
    logic                 w_idleSel;
    logic                 w_vendStart;
    logic [CREDIT_W-1:0]  w_changeNext;

    // Largest hopper coin not exceeding the remaining credit (500 never used).
    function automatic logic [2:0] greedyCode(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(100))     return 3'd4;
        else if (c >= CREDIT_W'(50)) return 3'd3;
        else if (c >= CREDIT_W'(25)) return 3'd2;
        else if (c >= CREDIT_W'(10)) return 3'd1;
        else                         return 3'd0;
    endfunction

    function automatic logic [CREDIT_W-1:0] changeValue(input logic [2:0] code);
        case (code)
            3'd4:    return CREDIT_W'(100);
            3'd3:    return CREDIT_W'(50);
            3'd2:    return CREDIT_W'(25);
            3'd1:    return CREDIT_W'(10);
            default: return CREDIT_W'(5);
        endcase
    endfunction

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            assign w_price[i]  = PRICES[i*CREDIT_W +: CREDIT_W];
            assign w_afford[i] = (r_credit >= w_price[i]) && w_inStock[i];
        end
    endgenerate

`ifdef STOCK_TRACK_EN
    // Per-slot stock counters, decremented when a vend of that slot starts.
    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_stock
            logic [STOCK_W-1:0] r_count;
            assign w_inStock[i] = (r_count != '0);
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_count <= STOCK_W'(STOCK_INIT);
                end else if (w_vendStart && w_selOneHot[i]) begin
                    r_count <= r_count - STOCK_W'(1);
                end
            end
        end
    endgenerate
`else
    // Stock is unlimited when tracking is disabled.
    logic w_unusedStockCfg;
    assign w_unusedStockCfg = (STOCK_W + STOCK_INIT) > 0;
    assign w_inStock        = '1;
`endif

    // Decode a coin pulse: only a single set bit is a valid coin.
    always_comb begin
        w_coinOne   = 1'b1;
        w_coinValue = '0;
        case (bus.coinIn)
            6'b000001: w_coinValue = c_SUM_W'(5);
            6'b000010: w_coinValue = c_SUM_W'(10);
            6'b000100: w_coinValue = c_SUM_W'(25);
            6'b001000: w_coinValue = c_SUM_W'(50);
            6'b010000: w_coinValue = c_SUM_W'(100);
            6'b100000: w_coinValue = c_SUM_W'(500);
            default:   w_coinOne   = 1'b0;
        endcase
    end

    assign w_coinSum  = c_SUM_W'(r_credit) + w_coinValue;
    assign w_coinFits = (w_coinSum <= c_SUM_W'(MAX_CREDIT));

    // Lowest-index selection wins when several buttons pulse together.
    always_comb begin
        w_selValid = 1'b0;
        w_selIdx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (bus.slotSel[i]) begin
                w_selValid = 1'b1;
                w_selIdx   = c_IDX_W'(i);
            end
        end
    end

    assign w_selOneHot  = NUM_SLOTS'(1) << w_selIdx;
    assign w_selPrice   = w_price[w_selIdx];
    assign w_idleSel    = (r_state == c_ST_IDLE) && (bus.coinIn == '0) && w_selValid;
    assign w_vendStart  = w_idleSel && ((w_afford & w_selOneHot) != '0);
    assign w_changeNext = r_credit - changeValue(r_changeCoin);

    // Main controller: credit, timed indications and change handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_timer       <= '0;
            r_credit      <= '0;
            r_showPrice   <= '0;
            r_changeValid <= 1'b0;
            r_changeCoin  <= '0;
            r_coinReject  <= 1'b0;
            r_greenLed    <= '0;
            r_redLed      <= '0;
            r_dispLed     <= '0;
        end else begin
            r_coinReject <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_greenLed <= w_afford;
                    if (bus.coinIn != '0) begin
                        // A coin takes precedence; a same-cycle select/cancel is dropped.
                        if (w_coinOne && w_coinFits) begin
                            r_credit <= w_coinSum[CREDIT_W-1:0];
                        end else begin
                            r_coinReject <= 1'b1;
                        end
                    end else if (w_selValid) begin
                        r_greenLed <= '0;
                        if (w_vendStart) begin
                            r_state   <= c_ST_VEND;
                            r_dispLed <= w_selOneHot;
                            r_credit  <= r_credit - w_selPrice;
                            r_timer   <= c_TMR_W'(VEND_CYCLES - 1);
                        end else begin
                            r_state     <= c_ST_SHOW;
                            r_redLed    <= w_selOneHot;
                            r_showPrice <= w_selPrice;
                            r_timer     <= c_TMR_W'(SHOW_CYCLES - 1);
                        end
                    end else if (bus.cancel && (r_credit != '0)) begin
                        r_greenLed    <= '0;
                        r_state       <= c_ST_CHANGE;
                        r_changeValid <= 1'b1;
                        r_changeCoin  <= greedyCode(r_credit);
                    end
                end
                c_ST_SHOW: begin
                    r_coinReject <= (bus.coinIn != '0);
                    if (r_timer == '0) begin
                        r_state    <= c_ST_IDLE;
                        r_redLed   <= '0;
                        r_greenLed <= w_afford;
                    end else begin
                        r_timer <= r_timer - c_TMR_W'(1);
                    end
                end
                c_ST_VEND: begin
                    r_coinReject <= (bus.coinIn != '0);
                    if (r_timer == '0) begin
                        r_state    <= c_ST_IDLE;
                        r_dispLed  <= '0;
                        r_greenLed <= w_afford;
                    end else begin
                        r_timer <= r_timer - c_TMR_W'(1);
                    end
                end
                c_ST_CHANGE: begin
                    r_coinReject <= (bus.coinIn != '0);
                    // Coin and code stay put until the hopper takes them.
                    if (bus.changeReady) begin
                        r_credit <= w_changeNext;
                        if (w_changeNext == '0) begin
                            r_state       <= c_ST_IDLE;
                            r_changeValid <= 1'b0;
                            r_changeCoin  <= '0;
                        end else begin
                            r_changeCoin <= greedyCode(w_changeNext);
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.changeValid = r_changeValid;
    assign bus.changeCoin  = r_changeCoin;
    assign bus.coinReject  = r_coinReject;
    assign bus.credit      = r_credit;
    assign bus.dispValue   = (r_state == c_ST_SHOW) ? r_showPrice : r_credit;
    assign bus.greenLed    = r_greenLed;
    assign bus.redLed      = r_redLed;
    assign bus.dispLed     = r_dispLed;
    assign bus.busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
